// File: rtl/fft_stage_controller_pkg.sv
// Shared constants and FSM encoding for the radix-2 DIT FFT stage sequencer,
// also used by the butterfly wrapper and RAM/ROM instantiation.
package fft_stage_controller_pkg;

  localparam int unsigned N_LOG2   = 3;
  localparam int unsigned BFLY_LAT = 2;
  localparam int unsigned RAM_LAT  = 1;
  localparam int unsigned PIPE     = RAM_LAT + BFLY_LAT;
  localparam int unsigned STAGE_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fft_addr_delay.sv
// Reset-clearable shift register that replays read-side enables/addresses
// as write-back strobes once the read and butterfly pipeline has drained.
module fft_addr_delay #(
  parameter int unsigned WIDTH = 2 * fft_stage_controller_pkg::N_LOG2 + 1,
  parameter int unsigned DEPTH = fft_stage_controller_pkg::PIPE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  import fft_stage_controller_pkg::*;

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_controller.sv
// In-place radix-2 DIT FFT sequencer: issues per-cycle butterfly read and
// twiddle addresses for every stage, then replays them as write-back addresses.
module fft_stage_controller #(
  parameter int unsigned N_LOG2   = fft_stage_controller_pkg::N_LOG2,
  parameter int unsigned BFLY_LAT = fft_stage_controller_pkg::BFLY_LAT,
  parameter int unsigned RAM_LAT  = fft_stage_controller_pkg::RAM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_stage,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  output logic [N_LOG2-2:0] o_tw_addr,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b
);
  import fft_stage_controller_pkg::*;

  localparam int unsigned AW     = N_LOG2;
  localparam int unsigned KW     = N_LOG2 - 1;
  localparam int unsigned DLY    = RAM_LAT + BFLY_LAT;
  localparam int unsigned HALF_N = 1 << (N_LOG2 - 1);
  localparam int unsigned CW     = (DLY > 1) ? $clog2(DLY) : 1;
  localparam int unsigned DW     = 2 * AW + 1;

  fsm_state_t         r_state, w_state_nxt;
  logic [KW-1:0]      r_k, w_k_nxt;
  logic [STAGE_W-1:0] r_s, w_s_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               w_rd_en_nxt, w_busy_nxt, w_done_nxt;

  logic               r_busy, r_done, r_rd_en;
  logic [AW-1:0]      r_rd_addr_a, r_rd_addr_b;
  logic [KW-1:0]      r_tw_addr;

  logic [AW-1:0]      w_half, w_pos, w_grp, w_addr_a, w_addr_b;
  logic [KW-1:0]      w_tw;
  logic [DW-1:0]      w_dly_in, w_dly_out;

  // Next state, counters and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = ISSUE;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      ISSUE: begin
        if (r_k == KW'(HALF_N - 1)) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      DRAIN: begin
        if (r_cnt == CW'(DLY - 1)) begin
          if (r_s < STAGE_W'(N_LOG2 - 1)) begin
            w_state_nxt = ISSUE;
            w_s_nxt     = r_s + STAGE_W'(1);
            w_k_nxt     = '0;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_rd_en_nxt = (w_state_nxt == ISSUE);
    w_busy_nxt  = (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
    w_done_nxt  = (w_state_nxt == DONE);
  end

  // Butterfly pair and twiddle index for the upcoming (stage, k)
  always_comb begin
    w_half   = AW'(1) << w_s_nxt;
    w_pos    = AW'(w_k_nxt) & (w_half - AW'(1));
    w_grp    = AW'(w_k_nxt) >> w_s_nxt;
    w_addr_a = (w_grp << (w_s_nxt + STAGE_W'(1))) | w_pos;
    w_addr_b = w_addr_a + w_half;
    w_tw     = KW'(w_pos << (STAGE_W'(KW) - w_s_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_s         <= w_s_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr_a <= w_rd_en_nxt ? w_addr_a : '0;
      r_rd_addr_b <= w_rd_en_nxt ? w_addr_b : '0;
      r_tw_addr   <= w_rd_en_nxt ? w_tw : '0;
    end
  end

  assign w_dly_in = {r_rd_en, r_rd_addr_a, r_rd_addr_b};

  fft_addr_delay #(
    .WIDTH(DW),
    .DEPTH(DLY)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_dly_in),
    .o_q (w_dly_out)
  );

  assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = w_dly_out;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stage     = r_s;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_addr_a;
  assign o_rd_addr_b = r_rd_addr_b;
  assign o_tw_addr   = r_tw_addr;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Bench for fft_stage_controller: N=8 and N=16 instances checked cycle by cycle
// against a butterfly-schedule model with a read-after-write scoreboard.
module tb_fft_stage_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start3 = 1'b0;
  logic start4 = 1'b0;

  logic       busy3, done3, rd3, wr3;
  logic [3:0] stage3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;

  logic       busy4, done4, rd4, wr4;
  logic [3:0] stage4;
  logic [3:0] ra4, rb4, wa4, wb4;
  logic [2:0] tw4;

  int checks = 0;
  int failures = 0;
  int s_busy, s_done, s_stage, s_rd, s_ra, s_rb, s_tw, s_wr, s_wa, s_wb;

  always #5 clk = ~clk;

  fft_stage_controller dut3 (
    .clk(clk), .rst(rst), .i_start(start3), .o_busy(busy3), .o_done(done3),
    .o_stage(stage3), .o_rd_en(rd3), .o_rd_addr_a(ra3), .o_rd_addr_b(rb3),
    .o_tw_addr(tw3), .o_wr_en(wr3), .o_wr_addr_a(wa3), .o_wr_addr_b(wb3)
  );

  fft_stage_controller #(.N_LOG2(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
    .o_stage(stage4), .o_rd_en(rd4), .o_rd_addr_a(ra4), .o_rd_addr_b(rb4),
    .o_tw_addr(tw4), .o_wr_en(wr4), .o_wr_addr_a(wa4), .o_wr_addr_b(wb4)
  );

  task automatic sample(input bit sel);
    if (!sel) begin
      s_busy = int'(busy3); s_done = int'(done3); s_stage = int'(stage3);
      s_rd = int'(rd3); s_ra = int'(ra3); s_rb = int'(rb3); s_tw = int'(tw3);
      s_wr = int'(wr3); s_wa = int'(wa3); s_wb = int'(wb3);
    end else begin
      s_busy = int'(busy4); s_done = int'(done4); s_stage = int'(stage4);
      s_rd = int'(rd4); s_ra = int'(ra4); s_rb = int'(rb4); s_tw = int'(tw4);
      s_wr = int'(wr4); s_wa = int'(wa4); s_wb = int'(wb4);
    end
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (!sel) start3 = v;
    else start4 = v;
  endtask

  task automatic idle_check(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(sel);
      checks++;
      if ((s_busy | s_done | s_rd | s_wr) !== 0)
        $display("FAIL idle dut%0d busy=%0d done=%0d rd=%0d wr=%0d expected all 0",
                 sel ? 16 : 8, s_busy, s_done, s_rd, s_wr);
      if ((s_busy | s_done | s_rd | s_wr) !== 0) failures++;
      @(posedge clk); #1;
    end
  endtask

  // Starts a run at the current cycle (cycle 0) and checks it cycle by cycle.
  // ign_a/ign_b: cycles carrying an extra start pulse; rst_at: cycle of async reset.
  task automatic run(input bit sel, input int nl, input int ign_a, input int ign_b,
                     input int rst_at);
    int n, h, l, last, k, si, off, cw, ws, wo;
    int erd, ebusy, edone, ewr, xa, xb, xt, xwa, xwb, zsum;
    int ea[4][8], eb[4][8], et[4][8];
    int wst[16];
    n = 1 << nl; h = n / 2; l = h + 3; last = nl * l + 1;
    for (int s = 0; s < nl; s++) begin
      int span;
      span = 1 << s;
      k = 0;
      for (int base = 0; base < n; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          ea[s][k] = base + j;
          eb[s][k] = base + j + span;
          et[s][k] = j * (n / (2 * span));
          k++;
        end
    end
    for (int i = 0; i < 16; i++) wst[i] = -1;

    set_start(sel, 1'b1);
    @(posedge clk); #1;
    for (int c = 1; c <= last; c++) begin
      set_start(sel, (c == ign_a) || (c == ign_b));
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1 sample(sel);
        zsum = s_busy | s_done | s_stage | s_rd | s_ra | s_rb | s_tw | s_wr | s_wa | s_wb;
        checks++;
        if (zsum !== 0) begin
          failures++;
          $display("FAIL async_reset cycle=%0d busy=%0d rd=%0d wr=%0d stage=%0d expected all 0",
                   c, s_busy, s_rd, s_wr, s_stage);
        end
        set_start(sel, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      @(negedge clk);
      sample(sel);

      si = (c - 1) / l; off = (c - 1) % l;
      erd = (si < nl && off < h) ? 1 : 0;
      ebusy = (c < last) ? 1 : 0;
      edone = (c == last) ? 1 : 0;
      cw = c - 3; ewr = 0; xwa = 0; xwb = 0; ws = 0;
      if (cw >= 1) begin
        ws = (cw - 1) / l; wo = (cw - 1) % l;
        if (ws < nl && wo < h) begin
          ewr = 1; xwa = ea[ws][wo]; xwb = eb[ws][wo];
        end
      end

      checks++;
      if (s_busy !== ebusy) begin
        failures++;
        $display("FAIL busy n=%0d cycle=%0d got=%0d exp=%0d", n, c, s_busy, ebusy);
      end
      checks++;
      if (s_done !== edone) begin
        failures++;
        $display("FAIL done n=%0d cycle=%0d got=%0d exp=%0d", n, c, s_done, edone);
      end
      checks++;
      if (s_rd !== erd) begin
        failures++;
        $display("FAIL rd_en n=%0d cycle=%0d got=%0d exp=%0d", n, c, s_rd, erd);
      end
      if (erd == 1) begin
        xa = ea[si][off]; xb = eb[si][off]; xt = et[si][off];
        checks++;
        if (s_ra !== xa || s_rb !== xb || s_tw !== xt) begin
          failures++;
          $display("FAIL rd_addr n=%0d cycle=%0d got=(%0d,%0d) tw=%0d exp=(%0d,%0d) tw=%0d",
                   n, c, s_ra, s_rb, s_tw, xa, xb, xt);
        end
      end
      if (ebusy == 1) begin
        checks++;
        if (s_stage !== si) begin
          failures++;
          $display("FAIL stage n=%0d cycle=%0d got=%0d exp=%0d", n, c, s_stage, si);
        end
      end
      checks++;
      if (s_wr !== ewr) begin
        failures++;
        $display("FAIL wr_en n=%0d cycle=%0d got=%0d exp=%0d", n, c, s_wr, ewr);
      end
      if (ewr == 1) begin
        checks++;
        if (s_wa !== xwa || s_wb !== xwb) begin
          failures++;
          $display("FAIL wr_addr n=%0d cycle=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                   n, c, s_wa, s_wb, xwa, xwb);
        end
      end
      // A read in stage s must see both locations already written by stage s-1
      if (s_rd == 1 && si > 0 && si < nl) begin
        checks++;
        if (s_ra >= 16 || s_rb >= 16 || wst[s_ra % 16] !== si - 1 || wst[s_rb % 16] !== si - 1) begin
          failures++;
          $display("FAIL raw_hazard n=%0d cycle=%0d addr=(%0d,%0d) last_wr_stage=(%0d,%0d) exp=%0d",
                   n, c, s_ra, s_rb, wst[s_ra % 16], wst[s_rb % 16], si - 1);
        end
      end
      if (s_wr == 1 && cw >= 1) begin
        wst[s_wa % 16] = ws;
        wst[s_wb % 16] = ws;
      end
      @(posedge clk); #1;
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start3 = 1'b1; start4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel[0]);
      checks++;
      if ((s_busy | s_done | s_stage | s_rd | s_ra | s_rb | s_tw | s_wr | s_wa | s_wb) !== 0) begin
        failures++;
        $display("FAIL reset_values dut_sel=%0d busy=%0d rd=%0d wr=%0d expected all 0",
                 sel, s_busy, s_rd, s_wr);
      end
    end
    @(posedge clk); #1;
    start3 = 1'b0; start4 = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int sel = 0; sel < 2; sel++) begin
        sample(sel[0]);
        checks++;
        if ((s_busy | s_done | s_stage | s_rd | s_ra | s_rb | s_tw | s_wr | s_wa | s_wb) !== 0) begin
          failures++;
          $display("FAIL idle_after_reset dut_sel=%0d cycle=%0d busy=%0d rd=%0d expected all 0",
                   sel, i, s_busy, s_rd);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stage_sequence();
    idle_check(0, int'($urandom_range(0, 4)));
    run(0, 3, 0, 0, 0);
    idle_check(0, 2);
  endtask

  task automatic test_ignored_starts();
    run(0, 3, 5, 22, 0);
    run(0, 3, 0, 0, 0);
    idle_check(0, 2);
  endtask

  task automatic test_async_reset();
    run(0, 3, 0, 0, 9);
    idle_check(0, 3);
    run(0, 3, 0, 0, 0);
    run(0, 3, 0, 0, int'($urandom_range(2, 21)));
    idle_check(0, 2);
    run(0, 3, 0, 0, 0);
    idle_check(0, 1);
  endtask

  task automatic test_n16();
    idle_check(1, 2);
    run(1, 4, int'($urandom_range(1, 45)), 0, 0);
    idle_check(1, 2);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      idle_check(0, int'($urandom_range(0, 3)));
      run(0, 3, int'($urandom_range(1, 22)), int'($urandom_range(1, 22)), 0);
    end
    idle_check(0, 2);
  endtask

  initial begin
    test_reset();
    test_stage_sequence();
    test_ignored_starts();
    test_async_reset();
    test_n16();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_controller.md
# fft_stage_controller

Sequencer for the in-place radix-2 decimation-in-time FFT built around the butterfly unit. On a start pulse it walks all log2(N) stages and issues, per cycle, one butterfly's RAM read addresses and twiddle ROM index. It then replays the same addresses, delayed to match the read and butterfly pipeline, as write-back addresses. Data RAM must already hold the input in bit-reversed order; the controller touches only addresses and enables, never data.

## Interface
- N_LOG2, 3: log2 of FFT length N; legal range 2..10.
- BFLY_LAT, 2: butterfly latency in cycles (multiplier register plus adder register).
- RAM_LAT, 1: data RAM read latency in cycles.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle start request; ignored while o_busy=1.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse when the final write-back has issued.
- o_stage  out  4  current stage index, 0..N_LOG2-1.
- o_rd_en  out  1  read strobe for both RAM ports.
- o_rd_addr_a  out  N_LOG2  butterfly top address.
- o_rd_addr_b  out  N_LOG2  butterfly bottom address.
- o_tw_addr  out  N_LOG2-1  twiddle ROM index.
- o_wr_en  out  1  write strobe for both RAM ports.
- o_wr_addr_a  out  N_LOG2  write address for the butterfly A output.
- o_wr_addr_b  out  N_LOG2  write address for the butterfly B output.

## Operation
- Define PIPE = RAM_LAT + BFLY_LAT; the default is 3.
- Reset values:
  - All outputs are 0.
  - The state machine is IDLE.
  - Stage and butterfly counters are 0.
  - The write delay line is cleared.
- IDLE:
  - i_start=1 goes to ISSUE, with stage s=0 and butterfly counter k=0.
- ISSUE:
  - o_rd_en=1 every cycle.
  - k runs from 0 to N/2-1.
  - When k=N/2-1, go to DRAIN.
- DRAIN:
  - o_rd_en=0 for exactly PIPE cycles.
  - On the last DRAIN cycle:
    - If s<N_LOG2-1, then s increments, k is cleared, and the state goes to ISSUE.
    - Otherwise go to DONE.
  - DRAIN exists so the next stage never reads a location before its write-back completes (read-after-write hazard).
- DONE:
  - o_done=1 and o_busy=0 for one cycle, then return to IDLE.
- Address arithmetic for stage s:
  - half = 1<<s, pos = k & (half-1), grp = k >> s.
  - o_rd_addr_a = (grp<<(s+1)) | pos.
  - o_rd_addr_b = o_rd_addr_a + half.
  - o_tw_addr = pos << (N_LOG2-1-s).
  - All values are unsigned; no wrap is possible.
- Write path:
  - {rd_en, addr_a, addr_b} passes through a PIPE-deep shift register.
  - o_wr_en and o_wr_addr_a/b equal the read-side values from PIPE cycles earlier.
- i_start while busy is dropped, with no queueing.
- i_start in the DONE cycle is ignored.
- rst mid-run: everything returns to reset values immediately, including pending writes. RAM contents are then undefined for the caller.

## Timing
- Read outputs (o_rd_*, o_tw_addr) are registered and valid in the same cycle as o_rd_en.
- i_start sampled high at cycle 0 gives o_busy=1 and the first read in cycle 1.
- Stage s:
  - Reads occupy cycles 1+s*(N/2+PIPE) through s*(N/2+PIPE)+N/2.
  - Writes occur exactly PIPE cycles later.
- o_done is high in cycle N_LOG2*(N/2+PIPE)+1. With the defaults this is cycle 22, and the last o_wr_en is in cycle 21.
- o_stage changes on the first ISSUE cycle of each stage and holds through DRAIN.

## Structure
- A shared package/header holds:
  - Constants N_LOG2, BFLY_LAT, RAM_LAT and the derived PIPE.
  - State encodings IDLE, ISSUE, DRAIN, DONE.
- The same package is used by the butterfly wrapper and the RAM/ROM instantiation.
- One sub-module, fft_addr_delay: a parameterised, reset-clearable shift register of width 2*N_LOG2+1 and depth PIPE, used for the write path.

## Test plan
- Reset, then idle for 10 cycles:
  - All outputs stay 0.
  - i_start asserted during rst has no effect.
- Defaults with start at cycle 0, stage 0 reads:
  - (0,1),(2,3),(4,5),(6,7), all with tw 0, in cycles 1-4.
- Stage 1 reads:
  - (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2, in cycles 8-11.
- Stage 2 reads:
  - (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3, in cycles 15-18.
  - o_done in cycle 22.
- Write alignment:
  - Every o_wr_en/o_wr_addr pair equals the read pair from 3 cycles earlier.
  - A scoreboard confirms no address is read before the previous stage's write to it.
- i_start pulsed at cycles 5 and 22:
  - Both are ignored.
  - A start at cycle 23 launches a new run with its first read in cycle 24.
- rst asserted asynchronously at cycle 9:
  - All outputs, including o_wr_en, drop to 0 before the next edge.
  - A later start yields the full sequence from stage 0.
- N_LOG2=4:
  - 4 stages of 8 reads each.
  - o_done at cycle 4*(8+3)+1 = 45.
